// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, default taps and seed helper for the LFSR keystream generator
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_t;

    localparam int          MAX_WIDTH    = 128;
    localparam logic [63:0] DEFAULT_TAPS = 64'hD800_0000_0000_0000;

    // An all-zero register is a lock-up state, so a zero seed becomes 1.
    function automatic logic [MAX_WIDTH-1:0] seed_fix(input logic [MAX_WIDTH-1:0] seed);
        return (seed == '0) ? {{(MAX_WIDTH-1){1'b0}}, 1'b1} : seed;
    endfunction

endpackage

// File: rtl/lfsr_step_en.sv
// rtl/lfsr_step_en.sv - step-rate divider producing a tick enable instead of a derived clock
module lfsr_step_en #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt;

    assign tick = (cnt == LAST);

    // A blocked tick parks the counter on LAST so the pending step is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                if (!hold) begin
                    cnt <= '0;
                end
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/lfsr_keystream_gen.sv
// rtl/lfsr_keystream_gen.sv - seeded Fibonacci LFSR emitting a handshaked keystream bit per step
module lfsr_keystream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter int               DIV   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_seed_valid,
    output logic             o_seed_ready,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_lfsr,
    output logic             o_keystream,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_steps
);

    lfsr_state_t      state_q;
    lfsr_state_t      state_d;
    logic             run;
    logic             div_clr;
    logic             seed_acc;
    logic             tick;
    logic             step;
    logic             fb;
    logic [WIDTH-1:0] seed_val;

    assign o_seed_ready = i_rst;
    assign seed_acc     = i_seed_valid;
    assign seed_val     = WIDTH'(seed_fix(MAX_WIDTH'(i_seed)));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (seed_acc) begin
            state_d = RUN;
        end
    end

    always_comb begin
        run     = (state_q == RUN);
        div_clr = seed_acc | ~run;
    end

    lfsr_step_en #(
        .DIV (DIV)
    ) u_step_en (
        .clk   (i_clk),
        .rst_n (i_rst),
        .clr   (div_clr),
        .en    (run & i_enable),
        .hold  (o_valid & ~i_ready),
        .tick  (tick)
    );

    assign step = run & i_enable & tick & (~o_valid | i_ready);
    assign fb   = ^(o_lfsr & TAPS);

    // A seed load discards whatever bit is pending, even one being consumed this cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_lfsr      <= '0;
            o_keystream <= 1'b0;
            o_valid     <= 1'b0;
            o_steps     <= '0;
        end else if (seed_acc) begin
            o_lfsr      <= seed_val;
            o_keystream <= 1'b0;
            o_valid     <= 1'b0;
            o_steps     <= '0;
        end else if (step) begin
            o_lfsr      <= {o_lfsr[WIDTH-2:0], fb};
            o_keystream <= o_lfsr[WIDTH-1];
            o_valid     <= 1'b1;
            o_steps     <= o_steps + 32'd1;
        end else if (o_valid && i_ready) begin
            o_valid     <= 1'b0;
        end
    end

endmodule
